// File: rtl/cpu_defs.sv
// Shared P4 core definitions: datapath widths, fixed register indices and the
// RegDst encodings, so the destination mux and the register file agree.
package cpu_defs;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PC_W   = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    RD_RT   = 2'b00,
    RD_RD   = 2'b01,
    RD_RA   = 2'b10,
    RD_COND = 2'b11
  } reg_dst_e;

endpackage

// File: rtl/grf_read_port.sv
// One combinational register-file read port.
// Priority: the $0 index reads as zero, then same-cycle write bypass, then stored value.
module grf_read_port #(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int ADDR_W = cpu_defs::ADDR_W
) (
  input  logic [ADDR_W-1:0] a_x,
  input  logic [ADDR_W-1:0] a3,
  input  logic              we,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] reg_val,
  output logic [DATA_W-1:0] rd
);
  import cpu_defs::*;

  always_comb begin
    if (a_x == ADDR_W'(REG_ZERO)) begin
      rd = '0;
    end else if (we && (a3 == a_x)) begin
      rd = wd;
    end else begin
      rd = reg_val;
    end
  end

endmodule

// File: rtl/grf_bypass.sv
// P4 general register file: 32 flop-based registers, two bypassed read ports,
// a hardwired $0 and a registered one-cycle write-trace record.
module grf_bypass #(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int ADDR_W = cpu_defs::ADDR_W,
  parameter int PC_W   = cpu_defs::PC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD,
  input  logic              WE,
  input  logic [PC_W-1:0]   PC,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              trace_valid,
  output logic [PC_W-1:0]   trace_pc,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [DATA_W-1:0] trace_data
);
  import cpu_defs::*;

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  logic              trace_valid_q, trace_valid_d;
  logic [PC_W-1:0]   trace_pc_q,    trace_pc_d;
  logic [ADDR_W-1:0] trace_addr_q,  trace_addr_d;
  logic [DATA_W-1:0] trace_data_q,  trace_data_d;

  // Bypass must not forward a write that reset is suppressing.
  logic we_eff;
  assign we_eff = WE & reset;

  always_comb begin
    regs_d = regs_q;
    if (WE && (A3 != ADDR_W'(REG_ZERO))) begin
      regs_d[A3] = WD;
    end
  end

  always_comb begin
    trace_valid_d = WE;
    trace_pc_d    = trace_pc_q;
    trace_addr_d  = trace_addr_q;
    trace_data_d  = trace_data_q;
    if (WE) begin
      trace_pc_d   = PC;
      trace_addr_d = A3;
      trace_data_d = WD;
    end
  end

  // Every entry sits on the async reset, which is why storage cannot be a RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_addr_q  <= '0;
      trace_data_q  <= '0;
    end else begin
      regs_q        <= regs_d;
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_addr_q  <= trace_addr_d;
      trace_data_q  <= trace_data_d;
    end
  end

  grf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .a_x     (A1),
    .a3      (A3),
    .we      (we_eff),
    .wd      (WD),
    .reg_val (regs_q[A1]),
    .rd      (RD1)
  );

  grf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .a_x     (A2),
    .a3      (A3),
    .we      (we_eff),
    .wd      (WD),
    .reg_val (regs_q[A2]),
    .rd      (RD2)
  );

  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_addr  = trace_addr_q;
  assign trace_data  = trace_data_q;

endmodule

// File: doc/grf_bypass.md
Name: grf_bypass

Overview:
General register file for the P4 MIPS core. It sits directly downstream of the RegDst destination mux and consumes its 5-bit A3 destination index, plus write data and a write enable. It provides two combinational read ports with same-cycle write-to-read bypass and a hardwired $0. It also emits a registered one-cycle write-trace record used by the grading/display harness.

Parameters:
DATA_W, 32, register and data width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W = 32
PC_W, 32, width of the PC carried into the trace record

Ports:
clk  input  1  core clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
A1  input  ADDR_W  read port 1 index (Instr[25:21])
A2  input  ADDR_W  read port 2 index (Instr[20:16])
A3  input  ADDR_W  write index, from the RegDst mux
WD  input  DATA_W  write data
WE  input  1  write enable (RegWrite)
PC  input  PC_W  PC of the instruction performing the write
RD1  output  DATA_W  read data, port 1
RD2  output  DATA_W  read data, port 2
trace_valid  output  1  one-cycle pulse: a write was committed on the previous edge
trace_pc  output  PC_W  PC of the traced write
trace_addr  output  ADDR_W  A3 of the traced write
trace_data  output  DATA_W  WD of the traced write

Behaviour:
- Reset (reset==0, asynchronous): all 32 registers go to 0; trace_valid, trace_pc, trace_addr and trace_data go to 0 immediately, without waiting for clk. While reset is low, WE is ignored. The first write can occur on the first rising edge after reset returns high.
- Write: on posedge clk with reset==1 and WE==1, reg[A3] <= WD, except when A3==0, where the register is left unchanged.
- $0: reg[0] reads as 0 at all times and is never written.
- Read (combinational, zero latency), evaluated independently for each port:
  - if Ax==0, then RDx = 0;
  - else if WE==1, reset==1 and A3==Ax, then RDx = WD (bypass, so a write and read of the same register in one cycle see the new value);
  - else RDx = reg[Ax].
- A1==A2: both ports return the same value, with the bypass applied to both.
- Trace: on every posedge with reset==1, trace_valid <= WE.
  - When WE==1: trace_pc <= PC, trace_addr <= A3, trace_data <= WD. This includes A3==0 writes: the record reports WD, but the register remains 0.
  - When WE==0: trace_pc, trace_addr and trace_data hold their previous values.
  - Latency from write edge to trace visible is exactly 1 cycle.
- Back-to-back writes to the same register: the last write wins, and each write produces its own trace pulse.
- Writes to $31 (jal path, RegDst=2'b10) have no special handling.
- Width rules: no arithmetic in this block. All data paths are exactly DATA_W wide, with no sign or zero extension.
- Storage is a flop array (32 x DATA_W). Inferring RAM is not allowed, because the async reset must clear every entry.

Decomposition:
- Shared package (cpu_defs): DATA_W=32, ADDR_W=5, REG_ZERO=5'd0, REG_RA=5'd31, and the RegDst encodings (RD_RT=2'b00, RD_RD=2'b01, RD_RA=2'b10, RD_COND=2'b11) so that the RegDst mux and this block share one source.
- One sub-module: grf_read_port, a combinational block taking Ax, A3, WE, WD and reg[Ax] and producing RDx with the $0 and bypass priority. It is instantiated twice.
- The storage array and trace register stay in the top module.

Test Plan:
1. Async reset: write reg[5]=32'hDEAD_BEEF, then drop reset mid-cycle (between clock edges). RD1 with A1=5 must read 0 before the next edge, and trace_valid must be 0 immediately.
2. Basic write/read: WE=1, A3=8, WD=32'h1234_5678, PC=32'h0000_3004. After the edge, A1=8 gives RD1=32'h1234_5678. The next cycle shows trace_valid=1, trace_pc=32'h0000_3004, trace_addr=8, trace_data=32'h1234_5678. The cycle after that shows trace_valid=0.
3. Bypass: reg[9]=1. In the same cycle set WE=1, A3=9, WD=7, A1=9, A2=9. Before the edge, RD1=RD2=7. After the edge with WE=0, both still read 7.
4. $0 protection: WE=1, A3=0, WD=32'hFFFF_FFFF. Before and after the edge, RD1 with A1=0 gives 0. The trace still reports trace_addr=0, trace_data=32'hFFFF_FFFF.
5. Reset vs. write: hold reset=0 with WE=1, A3=3, WD=5 across an edge. reg[3] must remain 0 and trace_valid must remain 0. After reset is released, the next edge with the same inputs writes reg[3]=5.
6. Sweep: write reg[i]=i*32'h0101_0101 for i=1..31 on consecutive edges. Read back all pairs via A1/A2; every value must match, 31 consecutive trace pulses must be observed, and reg[31] must equal 32'h1F1F_1F1F.
